// File: rtl/playback_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : playback_timer_pkg
// Purpose  : Shared types and BCD mm:ss arithmetic for the playback timer.
// Revision : 1.0 - initial release
// ============================================================================
package playback_timer_pkg;

    localparam int MAX_MIN_DIGITS = 8;
    localparam int MAX_TIME_W     = 4 * (MAX_MIN_DIGITS + 2);

    typedef logic [3:0]            bcd_digit_t;
    typedef logic [MAX_TIME_W-1:0] bcd_time_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        SEEK = 1'b1
    } state_t;

    // Digit vector is {minute digits..., s1, s0}; only min_digits minute digits are live.
    function automatic bcd_time_t bcd_time_inc(input bcd_time_t t, input int min_digits);
        bcd_time_t  r;
        bcd_digit_t d;
        logic       carry;
        r     = t;
        carry = 1'b1;
        d     = t[3:0];
        if (d == 4'd9) begin
            r[3:0] = 4'd0;
        end else begin
            r[3:0] = d + 4'd1;
            carry  = 1'b0;
        end
        d = t[7:4];
        if (carry) begin
            if (d == 4'd5) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = d + 4'd1;
                carry  = 1'b0;
            end
        end
        for (int i = 0; i < MAX_MIN_DIGITS; i++) begin
            d = t[8+4*i +: 4];
            if (carry && (i < min_digits)) begin
                if (d == 4'd9) begin
                    r[8+4*i +: 4] = 4'd0;
                end else begin
                    r[8+4*i +: 4] = d + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_time_dec(input bcd_time_t t, input int min_digits);
        bcd_time_t  r;
        bcd_digit_t d;
        logic       borrow;
        r      = t;
        borrow = 1'b1;
        d      = t[3:0];
        if (d == 4'd0) begin
            r[3:0] = 4'd9;
        end else begin
            r[3:0] = d - 4'd1;
            borrow = 1'b0;
        end
        d = t[7:4];
        if (borrow) begin
            if (d == 4'd0) begin
                r[7:4] = 4'd5;
            end else begin
                r[7:4] = d - 4'd1;
                borrow = 1'b0;
            end
        end
        for (int i = 0; i < MAX_MIN_DIGITS; i++) begin
            d = t[8+4*i +: 4];
            if (borrow && (i < min_digits)) begin
                if (d == 4'd0) begin
                    r[8+4*i +: 4] = 4'd9;
                end else begin
                    r[8+4*i +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic bcd_time_t bcd_time_max(input int min_digits);
        bcd_time_t r;
        r      = '0;
        r[3:0] = 4'd9;
        r[7:4] = 4'd5;
        for (int i = 0; i < MAX_MIN_DIGITS; i++) begin
            if (i < min_digits) begin
                r[8+4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_time_eq(input bcd_time_t a, input bcd_time_t b);
        return (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/playback_timer_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides clk by TICK_DIV into a one-cycle tick; phase held when en=0.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = en && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/playback_timer.sv
`default_nettype none
// ============================================================================
// Module   : playback_timer
// Purpose  : BCD mm:ss elapsed-time counter with length limit and saturating
//            ready/valid seek. PLAYBACK_TIMER_REMAINING_EN adds a remaining-time output.
// Revision : 1.0 - initial release
// ============================================================================
module playback_timer
    import playback_timer_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_DIGITS = 2,
    parameter int SEEK_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        count,
    input  logic                        load,
    input  logic [4*(MIN_DIGITS+2)-1:0] track_len,
    input  logic                        seek_valid,
    input  logic                        seek_dir,
    input  logic [SEEK_W-1:0]           seek_secs,
    output logic                        seek_ready,
`ifdef PLAYBACK_TIMER_REMAINING_EN
    output logic [4*(MIN_DIGITS+2)-1:0] remaining,
`endif
    output logic [3:0]                  seconds0,
    output logic [3:0]                  seconds1,
    output logic [4*MIN_DIGITS-1:0]     minutes,
    output logic                        done
);

    localparam int        TW         = 4 * (MIN_DIGITS + 2);
    localparam bcd_time_t c_MAX_FULL = bcd_time_max(MIN_DIGITS);

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_time, w_time_nxt;
    logic [TW-1:0]     r_len, w_len_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pend, w_pend_nxt;
    logic              r_dir, w_dir_nxt;
    logic              r_ready;
    logic [SEEK_W-1:0] r_seek_cnt, w_cnt_nxt;

    logic      w_tick;
    logic      w_step_up, w_step_dn;
    logic      w_len_nz, w_at_max, w_at_zero;
    logic      w_inc_hits_len, w_inc_is_max, w_dec_is_zero, w_last_step;
    bcd_time_t w_inc_full, w_dec_full;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (count & ~r_done),
        .tick  (w_tick)
    );

    assign w_inc_full     = bcd_time_inc(bcd_time_t'(r_time), MIN_DIGITS);
    assign w_dec_full     = bcd_time_dec(bcd_time_t'(r_time), MIN_DIGITS);
    assign w_len_nz       = (r_len != '0);
    assign w_at_max       = bcd_time_eq(bcd_time_t'(r_time), c_MAX_FULL);
    assign w_at_zero      = (r_time == '0);
    assign w_inc_hits_len = w_len_nz && bcd_time_eq(w_inc_full, bcd_time_t'(r_len));
    assign w_inc_is_max   = bcd_time_eq(w_inc_full, c_MAX_FULL);
    assign w_dec_is_zero  = (w_dec_full == '0);
    assign w_last_step    = (r_seek_cnt == SEEK_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_len_nxt   = r_len;
        w_done_nxt  = r_done;
        w_pend_nxt  = r_pend;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_seek_cnt;
        w_step_up   = 1'b0;
        w_step_dn   = 1'b0;
        if (load) begin
            w_len_nxt   = track_len;
            w_time_nxt  = '0;
            w_done_nxt  = 1'b0;
            w_pend_nxt  = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    // A tick held over from a seek is merged with any live tick.
                    if (w_tick || r_pend) begin
                        w_pend_nxt = 1'b0;
                        if (!r_done && !w_at_max) begin
                            w_time_nxt = w_inc_full[TW-1:0];
                            w_step_up  = 1'b1;
                            w_done_nxt = w_inc_hits_len;
                        end
                    end
                    if (seek_valid && (seek_secs != '0)) begin
                        w_cnt_nxt   = seek_secs;
                        w_dir_nxt   = seek_dir;
                        w_state_nxt = SEEK;
                    end
                end
                SEEK: begin
                    if (w_tick) begin
                        w_pend_nxt = 1'b1;
                    end
                    w_cnt_nxt = r_seek_cnt - SEEK_W'(1);
                    if (!r_dir) begin
                        if (r_done || w_at_max) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_time_nxt = w_inc_full[TW-1:0];
                            w_step_up  = 1'b1;
                            w_done_nxt = w_inc_hits_len;
                            if (w_inc_hits_len || w_inc_is_max || w_last_step) begin
                                w_state_nxt = RUN;
                            end
                        end
                    end else begin
                        if (w_at_zero) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_time_nxt = w_dec_full[TW-1:0];
                            w_step_dn  = 1'b1;
                            w_done_nxt = 1'b0;
                            if (w_dec_is_zero || w_last_step) begin
                                w_state_nxt = RUN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_time     <= '0;
            r_len      <= '0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
            r_dir      <= 1'b0;
            r_seek_cnt <= '0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_time     <= w_time_nxt;
            r_len      <= w_len_nxt;
            r_done     <= w_done_nxt;
            r_pend     <= w_pend_nxt;
            r_dir      <= w_dir_nxt;
            r_seek_cnt <= w_cnt_nxt;
            r_ready    <= (w_state_nxt == RUN);
        end
    end

    assign seek_ready = r_ready;
    assign seconds0   = r_time[3:0];
    assign seconds1   = r_time[7:4];
    assign minutes    = r_time[TW-1:8];
    assign done       = r_done;

`ifdef PLAYBACK_TIMER_REMAINING_EN
    logic [TW-1:0] r_rem, w_rem_nxt;
    bcd_time_t     w_rem_inc_full, w_rem_dec_full;
    logic          w_rem_unused;

    assign w_rem_inc_full = bcd_time_inc(bcd_time_t'(r_rem), MIN_DIGITS);
    assign w_rem_dec_full = bcd_time_dec(bcd_time_t'(r_rem), MIN_DIGITS);

    generate
        if (TW < MAX_TIME_W) begin : g_rem_narrow
            assign w_rem_unused = ^{w_rem_inc_full[MAX_TIME_W-1:TW],
                                    w_rem_dec_full[MAX_TIME_W-1:TW]};
        end else begin : g_rem_full
            assign w_rem_unused = 1'b0;
        end
    endgenerate

    // Remaining moves opposite to elapsed; an unlimited track keeps it at zero.
    always_comb begin
        w_rem_nxt = r_rem;
        if (load) begin
            w_rem_nxt = track_len;
        end else if (w_len_nz) begin
            if (w_step_up) begin
                w_rem_nxt = w_rem_dec_full[TW-1:0];
            end else if (w_step_dn) begin
                w_rem_nxt = w_rem_inc_full[TW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
        end else begin
            r_rem <= w_rem_nxt;
        end
    end

    assign remaining = r_rem;
`else
    logic w_step_unused;
    assign w_step_unused = w_step_up ^ w_step_dn;
`endif

endmodule
`default_nettype wire

// File: tb/tb_playback_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_playback_timer
// Purpose  : Directed plus random stimulus against an integer-seconds reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_playback_timer;

    localparam int TICK_DIV   = 4;
    localparam int MIN_DIGITS = 2;
    localparam int SEEK_W     = 8;
    localparam int MAXS       = 99 * 60 + 59;

    logic        clk = 1'b0;
    logic        reset, count, load, seek_valid, seek_dir;
    logic [15:0] track_len;
    logic [7:0]  seek_secs;
    logic        seek_ready, done;
    logic [3:0]  seconds0, seconds1;
    logic [7:0]  minutes;
`ifdef PLAYBACK_TIMER_REMAINING_EN
    logic [15:0] remaining;
`endif

    playback_timer #(
        .TICK_DIV   (TICK_DIV),
        .MIN_DIGITS (MIN_DIGITS),
        .SEEK_W     (SEEK_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .load       (load),
        .track_len  (track_len),
        .seek_valid (seek_valid),
        .seek_dir   (seek_dir),
        .seek_secs  (seek_secs),
        .seek_ready (seek_ready),
`ifdef PLAYBACK_TIMER_REMAINING_EN
        .remaining  (remaining),
`endif
        .seconds0   (seconds0),
        .seconds1   (seconds1),
        .minutes    (minutes),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: whole seconds, not digits.
    int m_el = 0, m_len = 0, m_phase = 0, m_left = 0;
    bit m_done = 0, m_pend = 0, m_seek = 0, m_dir = 0;

    function automatic logic [15:0] sec2bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int bcd2sec(input logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_step();
        bit tk;
        if (reset) begin
            m_el = 0; m_len = 0; m_phase = 0; m_left = 0;
            m_done = 0; m_pend = 0; m_seek = 0;
        end else if (load) begin
            m_len = bcd2sec(track_len);
            m_el = 0; m_done = 0; m_pend = 0; m_seek = 0; m_phase = 0;
        end else begin
            tk = count && !m_done && (m_phase == TICK_DIV - 1);
            if (count && !m_done) m_phase = (m_phase + 1) % TICK_DIV;
            if (!m_seek) begin
                if (tk || m_pend) begin
                    m_pend = 0;
                    if (!m_done && m_el < MAXS) begin
                        m_el++;
                        if (m_len != 0 && m_el == m_len) m_done = 1;
                    end
                end
                if (seek_valid && seek_secs != 0) begin
                    m_seek = 1; m_left = int'(seek_secs); m_dir = seek_dir;
                end
            end else begin
                if (tk) m_pend = 1;
                if (!m_dir) begin
                    if (m_done || m_el == MAXS) m_seek = 0;
                    else begin
                        m_el++; m_left--;
                        if (m_len != 0 && m_el == m_len) m_done = 1;
                        if (m_done || m_el == MAXS || m_left == 0) m_seek = 0;
                    end
                end else begin
                    if (m_el == 0) m_seek = 0;
                    else begin
                        m_el--; m_left--; m_done = 0;
                        if (m_el == 0 || m_left == 0) m_seek = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] e;
        e = sec2bcd(m_el);
        chk("seconds0",   32'(seconds0),   32'(e[3:0]));
        chk("seconds1",   32'(seconds1),   32'(e[7:4]));
        chk("minutes",    32'(minutes),    32'(e[15:8]));
        chk("done",       32'(done),       32'(m_done));
        chk("seek_ready", 32'(seek_ready), 32'(!m_seek));
`ifdef PLAYBACK_TIMER_REMAINING_EN
        chk("remaining",  32'(remaining),  32'((m_len != 0) ? sec2bcd(m_len - m_el) : 16'h0));
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic seek(input bit dir, input logic [7:0] secs);
        seek_valid = 1'b1; seek_dir = dir; seek_secs = secs;
        cyc();
        seek_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; count = 1'b0; load = 1'b0; seek_valid = 1'b0;
        seek_dir = 1'b0; track_len = 16'h0; seek_secs = 8'h0;
        repeat (3) cyc();
        chk("rst_time",  32'({minutes, seconds1, seconds0}), 32'h0);
        chk("rst_ready", 32'(seek_ready), 32'h1);
        reset = 1'b0; count = 1'b1;

        repeat (40 * TICK_DIV) cyc();
        chk("t40", 32'({minutes, seconds1, seconds0}), 32'h0040);
        repeat (20 * TICK_DIV) cyc();
        chk("t60", 32'({minutes, seconds1, seconds0}), 32'h0100);

        repeat (2) cyc();
        count = 1'b0;
        repeat (10) cyc();
        chk("pause", 32'({minutes, seconds1, seconds0}), 32'h0100);
        count = 1'b1;
        repeat (2) cyc();
        chk("resume_phase", 32'({minutes, seconds1, seconds0}), 32'h0101);

        track_len = 16'h0005; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (5 * TICK_DIV) cyc();
        chk("len5_done", 32'({done, seconds1, seconds0}), 32'h105);
        repeat (20) cyc();
        chk("len5_hold", 32'({done, seconds1, seconds0}), 32'h105);

        track_len = 16'h0020; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (3 * TICK_DIV) cyc();
        count = 1'b0;
        chk("at3", 32'({seconds1, seconds0}), 32'h03);
        seek(1'b0, 8'd10);
        repeat (10) cyc();
        chk("fwd10", 32'({seek_ready, seconds1, seconds0}), 32'h113);
        seek(1'b1, 8'd20);
        repeat (13) cyc();
        chk("back_sat", 32'({seek_ready, seconds1, seconds0}), 32'h100);

        count = 1'b1;
        seek(1'b0, 8'd5);
        repeat (5) cyc();
        chk("mid_tick_a", 32'({seek_ready, seconds1, seconds0}), 32'h105);
        cyc();
        chk("mid_tick_b", 32'({seconds1, seconds0}), 32'h06);

        count = 1'b0;
        seek(1'b0, 8'd10);
        repeat (3) cyc();
        track_len = 16'h0130; load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load_abort", 32'({seek_ready, seconds1, seconds0}), 32'h100);

        count = 1'b1;
        repeat (45 * TICK_DIV) cyc();
        chk("t45", 32'({minutes, seconds1, seconds0}), 32'h0045);
        count = 1'b0;
        seek(1'b1, 8'd15);
        repeat (15) cyc();
        chk("back15", 32'({minutes, seconds1, seconds0}), 32'h0030);
`ifdef PLAYBACK_TIMER_REMAINING_EN
        chk("rem_back15", 32'(remaining), 32'h0100);
`endif

        repeat (800) begin
            int mm, ss;
            count      = ($urandom % 4) != 0;
            seek_valid = ($urandom % 6) == 0;
            seek_dir   = $urandom % 2;
            seek_secs  = 8'($urandom % 20);
            load       = ($urandom % 80) == 0;
            mm         = $urandom % 3;
            ss         = $urandom % 60;
            track_len  = (($urandom % 4) == 0) ? 16'h0 :
                         {4'd0, 4'(mm), 4'(ss / 10), 4'(ss % 10)};
            reset      = ($urandom % 300) == 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
